// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word and emits it one bit per clock.
// Optional even-parity trailer bit enabled by defining SERIAL_TRANSMITTER_PARITY_EN.
module serial_transmitter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             dataInValid,
    output logic             dataInReady,
    output logic             dataOut,
    output logic             frameOut,
    output logic             busy,
    output logic [1:0]       stateDbg
);

    // Handshake: a word transfers on a rising edge where dataInValid and
    // dataInReady are both high; ready is high only in IDLE.

    localparam int CNT_W = $clog2(WIDTH);

`ifdef SERIAL_TRANSMITTER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t             state;
    state_t             nextState;
    logic [WIDTH-1:0]   shiftReg;
    logic [CNT_W-1:0]   bitCnt;
    logic               firstBit;
    logic               accept;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    logic               parityAcc;
`endif

    assign firstBit = (MSB_FIRST != 0) ? shiftReg[WIDTH-1] : shiftReg[0];
    assign accept   = (state == IDLE) && dataInValid;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (dataInValid) nextState = SHIFT;
            SHIFT: begin
                if (bitCnt == '0) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                    nextState = PARITY;
`else
                    nextState = IDLE;
`endif
                end
            end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            PARITY: nextState = IDLE;
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            parityAcc <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (accept) begin
                shiftReg <= dataIn;
                bitCnt   <= CNT_W'(WIDTH - 1);
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                parityAcc <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                // Shift toward the output end; vacated positions fill with zero.
                if (MSB_FIRST != 0)
                    shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
                else
                    shiftReg <= {1'b0, shiftReg[WIDTH-1:1]};
                if (bitCnt != '0)
                    bitCnt <= bitCnt - 1'b1;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                parityAcc <= parityAcc ^ firstBit;
`endif
            end
        end
    end

    assign dataInReady = (state == IDLE);
    assign busy        = (state != IDLE);
    assign frameOut    = (state != IDLE);
    assign stateDbg    = state;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    assign dataOut = ((state == SHIFT) && firstBit) || ((state == PARITY) && parityAcc);
`else
    assign dataOut = (state == SHIFT) && firstBit;
`endif

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboard bench for serial_transmitter: one MSB-first and one LSB-first instance, WIDTH=8.
module tb_serial_transmitter;

    localparam int WIDTH = 8;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] dataInA = '0, dataInB = '0;
    logic             validA = 1'b0, validB = 1'b0;
    logic             readyA, readyB, dataOutA, dataOutB;
    logic             frameOutA, frameOutB, busyA, busyB;
    logic [1:0]       stateA, stateB;

    int  checks = 0;
    int  failures = 0;
    logic monEn = 1'b0;
    logic [0:0] expQA[$];
    logic [0:0] expQB[$];

    serial_transmitter #(.WIDTH(WIDTH), .MSB_FIRST(1)) dutA (
        .clk(clk), .reset(reset), .dataIn(dataInA), .dataInValid(validA),
        .dataInReady(readyA), .dataOut(dataOutA), .frameOut(frameOutA),
        .busy(busyA), .stateDbg(stateA)
    );

    serial_transmitter #(.WIDTH(WIDTH), .MSB_FIRST(0)) dutB (
        .clk(clk), .reset(reset), .dataIn(dataInB), .dataInValid(validB),
        .dataInReady(readyB), .dataOut(dataOutB), .frameOut(frameOutB),
        .busy(busyB), .stateDbg(stateB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected bit sequence for a word, independent of the DUT shift logic.
    task automatic pushExpected(input bit sel, input logic [WIDTH-1:0] d);
        logic [0:0] b;
        for (int k = 0; k < WIDTH; k++) begin
            b = sel ? d[k] : d[WIDTH-1-k];
            if (sel) expQB.push_back(b); else expQA.push_back(b);
        end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
        b = ^d;
        if (sel) expQB.push_back(b); else expQA.push_back(b);
`endif
    endtask

    // Called just after a rising edge; waits for ready, transfers one word.
    task automatic sendWord(input bit sel, input logic [WIDTH-1:0] d, input bit holdValid,
                            output int waited);
        waited = 0;
        if (sel) begin dataInB = d; validB = 1'b1; end
        else     begin dataInA = d; validA = 1'b1; end
        while (!(sel ? readyB : readyA) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) check("ready_timeout", 0, 1);
        pushExpected(sel, d);
        @(posedge clk); #1;
        if (!holdValid) begin
            if (sel) validB = 1'b0; else validA = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busyA || busyB || expQA.size() != 0 || expQB.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            if (frameOutA) begin
                check("a_busy", busyA, 1);
                check("a_ready", readyA, 0);
                if (expQA.size() == 0) check("a_unexpected_bit", frameOutA, 0);
                else check("a_bit", dataOutA, expQA.pop_front());
            end else begin
                check("a_idle_data", dataOutA, 0);
            end
            if (frameOutB) begin
                check("b_busy", busyB, 1);
                if (expQB.size() == 0) check("b_unexpected_bit", frameOutB, 0);
                else check("b_bit", dataOutB, expQB.pop_front());
            end else begin
                check("b_idle_data", dataOutB, 0);
            end
        end
    end

    initial begin
        int w;
        logic [WIDTH-1:0] r;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", readyA, 1);
        check("rst_busy", busyA, 0);
        check("rst_frame", frameOutA, 0);
        check("rst_data", dataOutA, 0);
        check("rst_state", stateA, 0);
        monEn = 1'b1;
        @(posedge clk); #1;

        // A5 MSB-first: ready returns exactly FRAME_LEN cycles after acceptance.
        sendWord(0, 8'hA5, 0, w);
        repeat (FRAME_LEN - 1) @(posedge clk);
        #1 check("a5_ready_late", readyA, 0);
        @(posedge clk); #1;
        check("a5_ready_back", readyA, 1);
        drain();

        sendWord(1, 8'h01, 0, w);
        drain();
        sendWord(0, 8'h07, 0, w);
        drain();
        sendWord(0, 8'h03, 0, w);
        drain();

        // Valid held high: second word waits through exactly one frame.
        sendWord(0, 8'hFF, 1, w);
        sendWord(0, 8'h00, 0, w);
        check("b2b_wait", w, FRAME_LEN);
        drain();

        for (int i = 0; i < 6; i++) begin
            r = WIDTH'($urandom_range(0, 255));
            sendWord(i[0], r, 0, w);
            drain();
        end

        // Reset during bit 3 aborts the frame.
        sendWord(0, 8'hC3, 0, w);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expQA.delete();
        check("abort_data", dataOutA, 0);
        check("abort_frame", frameOutA, 0);
        check("abort_busy", busyA, 0);
        check("abort_ready", readyA, 1);
        repeat (FRAME_LEN) @(posedge clk);
        #1;

        // Reset wins over a simultaneous valid.
        dataInA = 8'hAA; validA = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; validA = 1'b0;
        check("rstv_ready", readyA, 1);
        check("rstv_busy", busyA, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rstv_frame", frameOutA, 0);
        end

        drain();
        check("a_queue_empty", expQA.size(), 0);
        check("b_queue_empty", expQB.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
